imem_fetch_ctrl: RTL and testbench

- Instruction-fetch sequencer for the LEGv8 single-cycle datapath. It sits between the PC logic and the 64-word combinational instruction ROM (6-bit word address, 32-bit data).
- It owns the fetch PC, drives the ROM address and buffers fetched words in a small prefetch queue. Words are handed to decode with a valid/ready handshake.
- Decode stalls and branch redirects are absorbed here, so the ROM is addressed by exactly one sequenced source.

---
 rtl/imem_fetch_ctrl.sv | 145 ++++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : imem_fetch_ctrl
// Brief    : LEGv8 fetch sequencer. Owns the fetch PC, addresses the ROM and
//            buffers words in a prefetch queue handed to decode via valid/ready.
//            Optional: FETCH_HALT_EN stops fetching on a 32'h0 padding word.
// Revision : 1.0 - initial release
// ============================================================================
module imem_fetch_ctrl #(
  parameter int             N        = 64,
  parameter int             AW       = 6,
  parameter int             DEPTH    = 2,
  parameter logic [N-1:0]   RESET_PC = '0,
  parameter int             CW       = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  output logic [AW-1:0] imem_addr,
  input  logic [31:0]   imem_q,
  output logic          inst_valid,
  input  logic          inst_ready,
  output logic [31:0]   inst,
  output logic [N-1:0]  inst_pc,
  input  logic          redirect_valid,
  input  logic [N-1:0]  redirect_pc,
  output logic          halted,
  output logic [CW-1:0] fetched_count
);

  localparam int         PW      = $clog2(DEPTH);
  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_FETCH = 2'd1;
  localparam logic [1:0] c_HALT  = 2'd2;
  localparam logic [PW:0] c_DEPTH = (PW+1)'(DEPTH);

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [N-1:0]  r_fetch_pc;
  logic [31:0]   r_q_inst [DEPTH];
  logic [N-1:0]  r_q_pc   [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [PW:0]   r_count;
  logic [CW-1:0] r_fetched;

  logic w_pop;
  logic w_try;
  logic w_pad;
  logic w_push;
  logic w_halt_go;
  logic w_halted;
  logic w_unused_ok;

  assign w_unused_ok = ^redirect_pc[1:0];

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a padding hit wins over a same-cycle enable drop
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (enable) w_state_nxt = c_FETCH;
      c_FETCH: begin
        if (w_halt_go)    w_state_nxt = c_HALT;
        else if (!enable) w_state_nxt = c_IDLE;
      end
      c_HALT:  if (redirect_valid) w_state_nxt = enable ? c_FETCH : c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    w_pop = (r_count != '0) && inst_ready;
    w_try = (r_state == c_FETCH) && !redirect_valid &&
            ((r_count < c_DEPTH) || w_pop);
`ifdef FETCH_HALT_EN
    w_pad    = (imem_q == 32'h0);
    w_halted = (r_state == c_HALT);
`else
    w_pad    = 1'b0;
    w_halted = 1'b0;
`endif
    w_push    = w_try && !w_pad;
    w_halt_go = w_try && w_pad;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_fetched  <= '0;
    end else begin
      // A pop alongside a redirect still consumed the head
      if (w_pop && (r_fetched != '1)) begin
        r_fetched <= r_fetched + CW'(1);
      end
      if (redirect_valid) begin
        r_fetch_pc <= {redirect_pc[N-1:2], 2'b00};
        r_rd_ptr   <= '0;
        r_wr_ptr   <= '0;
        r_count    <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr   <= r_wr_ptr + PW'(1);
          r_fetch_pc <= r_fetch_pc + N'(4);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PW'(1);
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + (PW+1)'(1);
          2'b01:   r_count <= r_count - (PW+1)'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_inst[r_wr_ptr] <= imem_q;
      r_q_pc[r_wr_ptr]   <= r_fetch_pc;
    end
  end

  assign imem_addr     = r_fetch_pc[AW+1:2];
  assign inst_valid    = (r_count != '0);
  assign inst          = inst_valid ? r_q_inst[r_rd_ptr] : '0;
  assign inst_pc       = inst_valid ? r_q_pc[r_rd_ptr] : '0;
  assign halted        = w_halted;
  assign fetched_count = r_fetched;

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_fetch_ctrl
// Brief    : Directed self-checking bench for imem_fetch_ctrl (two instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] rom [64];

  logic        rst0, en0, rdy0, rv0, v0, h0;
  logic [63:0] rpc0, ipc0;
  logic [5:0]  addr0;
  logic [31:0] q0, inst0;
  logic [15:0] cnt0;

  logic        rst1, en1, rdy1, rv1, v1, h1;
  logic [63:0] rpc1, ipc1;
  logic [5:0]  addr1;
  logic [31:0] q1, inst1;
  logic [2:0]  cnt1;

  assign q0 = rom[addr0];
  assign q1 = rom[addr1];

  imem_fetch_ctrl dut0 (
    .clk(clk), .reset(rst0), .enable(en0), .imem_addr(addr0), .imem_q(q0),
    .inst_valid(v0), .inst_ready(rdy0), .inst(inst0), .inst_pc(ipc0),
    .redirect_valid(rv0), .redirect_pc(rpc0), .halted(h0), .fetched_count(cnt0)
  );

  imem_fetch_ctrl #(.RESET_PC(64'hF8), .CW(3)) dut1 (
    .clk(clk), .reset(rst1), .enable(en1), .imem_addr(addr1), .imem_q(q1),
    .inst_valid(v1), .inst_ready(rdy1), .inst(inst1), .inst_pc(ipc1),
    .redirect_valid(rv1), .redirect_pc(rpc1), .halted(h1), .fetched_count(cnt1)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'hA000_0000 + i;
    rst0 = 1; en0 = 0; rdy0 = 0; rv0 = 0; rpc0 = '0;
    rst1 = 1; en1 = 0; rdy1 = 0; rv1 = 0; rpc1 = '0;
    tick; tick;

    chk("rst_valid", 64'(v0), 64'd0);
    chk("rst_count", 64'(cnt0), 64'd0);
    chk("rst_addr", 64'(addr0), 64'd0);
    chk("rst_inst", 64'(inst0), 64'd0);
    chk("rst_pc", ipc0, 64'd0);
    chk("rst_halted", 64'(h0), 64'd0);
    chk("rst_addr1", 64'(addr1), 64'd62);

    // Continuous fetch on both instances
    rst0 = 0; rst1 = 0; en0 = 1; rdy0 = 1; en1 = 1; rdy1 = 1;
    tick;
    chk("en_no_valid_yet", 64'(v0), 64'd0);
    tick;
    chk("first_valid", 64'(v0), 64'd1);
    for (int k = 0; k < 4; k++) begin
      if (k != 0) tick;
      chk("seq_pc", ipc0, 64'(4 * k));
      chk("seq_inst", 64'(inst0), 64'(32'hA000_0000 + k));
      chk("wrap_pc", ipc1, 64'(64'hF8 + 4 * k));
      chk("wrap_inst", 64'(inst1), 64'(32'hA000_0000 + ((62 + k) % 64)));
      chk("wrap_addr", 64'(addr1), 64'((63 + k) % 64));
    end
    chk("count3", 64'(cnt0), 64'd3);
    repeat (8) tick;
    chk("count_sat", 64'(cnt1), 64'd7);

    // Stall: queue fills, address holds
    rst0 = 1; tick;
    rst0 = 0; en0 = 1; rdy0 = 0;
    repeat (6) tick;
    chk("stall_valid", 64'(v0), 64'd1);
    chk("stall_head", ipc0, 64'd0);
    chk("stall_addr", 64'(addr0), 64'd2);
    rdy0 = 1;
    tick; chk("drain_pc4", ipc0, 64'd4);
    tick; chk("drain_pc8", ipc0, 64'd8);
    rdy0 = 0;
    chk("drain_count", 64'(cnt0), 64'd2);
    chk("full_addr", 64'(addr0), 64'd4);

    // Redirect flushes queued pcs 8,12
    rv0 = 1; rpc0 = 64'h43; tick; rv0 = 0;
    chk("redir_flush", 64'(v0), 64'd0);
    chk("redir_addr", 64'(addr0), 64'd16);
    tick;
    chk("redir_pc", ipc0, 64'h40);
    chk("redir_inst", 64'(inst0), 64'hA000_0010);
    chk("redir_count", 64'(cnt0), 64'd2);
    rdy0 = 1; tick;
    chk("redir_next", ipc0, 64'h44);
    chk("redir_count3", 64'(cnt0), 64'd3);

    // Redirect with concurrent pop still counts
    rv0 = 1; rpc0 = 64'h10; tick; rv0 = 0; rdy0 = 0;
    chk("rpop_valid", 64'(v0), 64'd0);
    chk("rpop_count", 64'(cnt0), 64'd4);
    chk("rpop_addr", 64'(addr0), 64'd4);
    tick;
    chk("rpop_pc", ipc0, 64'h10);
    chk("rpop_inst", 64'(inst0), 64'hA000_0004);

    // Enable drop: one more push, then queue drains
    en0 = 0; tick; tick;
    chk("dis_addr", 64'(addr0), 64'd6);
    chk("dis_valid", 64'(v0), 64'd1);
    rdy0 = 1; tick;
    chk("dis_pc", ipc0, 64'h14);
    tick;
    chk("dis_empty", 64'(v0), 64'd0);
    chk("dis_count", 64'(cnt0), 64'd6);
    chk("dis_addr2", 64'(addr0), 64'd6);

    // Mid-operation reset with two queued entries
    en0 = 1; rdy0 = 1; tick; tick;
    chk("re_pc18", ipc0, 64'h18);
    tick; rdy0 = 0; tick;
    chk("pre_rst_count", 64'(cnt0), 64'd7);
    chk("pre_rst_pc", ipc0, 64'h1C);
    rst0 = 1; tick; rst0 = 0;
    chk("mid_rst_valid", 64'(v0), 64'd0);
    chk("mid_rst_count", 64'(cnt0), 64'd0);
    chk("mid_rst_addr", 64'(addr0), 64'd0);
    chk("mid_rst_inst", 64'(inst0), 64'd0);
    tick;
    chk("idle_after_rst", 64'(v0), 64'd0);
    tick;
    chk("resume_valid", 64'(v0), 64'd1);
    chk("resume_pc", ipc0, 64'd0);

`ifdef FETCH_HALT_EN
    rom[5] = 32'h0;
    rst0 = 1; tick;
    rst0 = 0; en0 = 1; rdy0 = 1;
    for (int k = 0; k < 12; k++) begin
      tick;
      chk("no_pad", 64'(v0 && (inst0 == 32'h0)), 64'd0);
    end
    chk("halt_flag", 64'(h0), 64'd1);
    chk("halt_addr", 64'(addr0), 64'd5);
    chk("halt_count", 64'(cnt0), 64'd5);
    rv0 = 1; rpc0 = 64'h0; tick; rv0 = 0;
    chk("halt_clear", 64'(h0), 64'd0);
    tick;
    chk("halt_resume", ipc0, 64'd0);
`else
    rom[5] = 32'h0;
    rv0 = 1; rpc0 = 64'h14; tick; rv0 = 0;
    tick;
    chk("pad_valid", 64'(v0), 64'd1);
    chk("pad_pc", ipc0, 64'h14);
    chk("pad_inst", 64'(inst0), 64'd0);
    chk("pad_halted", 64'(h0), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
